// File: rtl/mem_port_arbiter_pkg.sv
// Memory-port constants shared by the LSU, the RAM wrapper and the port-B arbiter:
// op codes, access sizes, arbiter states and the alignment rule.
package mem_port_arbiter_pkg;

  localparam logic [1:0] MEM_OP_DISABLE   = 2'b00;
  localparam logic [1:0] MEM_OP_READ_SEXT = 2'b01;
  localparam logic [1:0] MEM_OP_READ_ZEXT = 2'b10;
  localparam logic [1:0] MEM_OP_WRITE     = 2'b11;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    BLOCKED
  } arb_state_e;

  // Size code 2'b11 is not a legal access width and is reported like a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = lo[0];
      SIZE_WORD: is_misaligned = (lo != 2'b00);
      default:   is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lane.sv
// Byte-lane handling for port B: write-enable mask, write-data replication,
// alignment check and load-data shift/extension. Purely combinational.
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  wr_size,
  input  logic [1:0]  wr_lo,
  input  logic [31:0] wr_data,
  output logic [3:0]  wr_web,
  output logic [31:0] wr_din,
  output logic        misaligned,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_lo,
  input  logic        rd_sext,
  input  logic [31:0] rd_raw,
  output logic [31:0] rd_data
);

  logic [31:0] rd_shift;

  always_comb begin
    misaligned = is_misaligned(wr_size, wr_lo);
    case (wr_size)
      SIZE_BYTE: begin
        wr_web = 4'b0001 << wr_lo;
        wr_din = {4{wr_data[7:0]}};
      end
      SIZE_HALF: begin
        wr_web = 4'b0011 << wr_lo;
        wr_din = {2{wr_data[15:0]}};
      end
      default: begin
        wr_web = 4'b1111;
        wr_din = wr_data;
      end
    endcase
  end

  always_comb begin
    rd_shift = rd_raw >> {rd_lo, 3'b000};
    case (rd_size)
      SIZE_BYTE: rd_data = {{24{rd_sext & rd_shift[7]}}, rd_shift[7:0]};
      SIZE_HALF: rd_data = {{16{rd_sext & rd_shift[15]}}, rd_shift[15:0]};
      default:   rd_data = rd_shift;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing data-RAM port B between the LSU (loads/stores)
// and the program loader (word stores). Grants and RAM strobes are same-cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter logic [1:0] MEM_DISABLE   = MEM_OP_DISABLE,
  parameter logic [1:0] MEM_READ_SEXT = MEM_OP_READ_SEXT,
  parameter logic [1:0] MEM_READ_ZEXT = MEM_OP_READ_ZEXT,
  parameter logic [1:0] MEM_WRITE     = MEM_OP_WRITE,
  parameter int         READ_LATENCY  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  lsu_op,
  input  logic [1:0]  lsu_size,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_gnt,
  input  logic        ldr_req,
  input  logic [31:0] ldr_addr,
  input  logic [31:0] ldr_wdata,
  output logic        ldr_gnt,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        ram_en,
  output logic [3:0]  ram_web,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout
);

  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_ldr_q, last_ldr_d;
  logic             rd_sext_q, rd_sext_d;
  logic [1:0]       rd_size_q, rd_size_d;
  logic [1:0]       rd_lo_q, rd_lo_d;

  logic [3:0]  wr_web;
  logic [31:0] wr_din;
  logic [31:0] rd_ext;
  logic        misaligned;
  logic        rd_done;
  logic        can_issue;
  logic        lsu_pend;
  logic        ldr_pend;
  logic        lsu_is_read;

  mem_lane_align u_lane (
    .wr_size    (lsu_size),
    .wr_lo      (lsu_addr[1:0]),
    .wr_data    (lsu_wdata),
    .wr_web     (wr_web),
    .wr_din     (wr_din),
    .misaligned (misaligned),
    .rd_size    (rd_size_q),
    .rd_lo      (rd_lo_q),
    .rd_sext    (rd_sext_q),
    .rd_raw     (ram_dout),
    .rd_data    (rd_ext)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_ldr_q <= 1'b1;
      rd_sext_q  <= 1'b0;
      rd_size_q  <= SIZE_BYTE;
      rd_lo_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_ldr_q <= last_ldr_d;
      rd_sext_q  <= rd_sext_d;
      rd_size_q  <= rd_size_d;
      rd_lo_q    <= rd_lo_d;
    end
  end

  // Response cycles (read data or error) double as issue cycles, but the
  // loader is held off in them so a response never shares a cycle with it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_ldr_d = last_ldr_q;
    rd_sext_d  = rd_sext_q;
    rd_size_d  = rd_size_q;
    rd_lo_d    = rd_lo_q;
    lsu_gnt    = 1'b0;
    ldr_gnt    = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_data   = '0;
    ram_en     = 1'b0;
    ram_web    = 4'b0000;
    ram_addr   = '0;
    ram_din    = '0;

    rd_done     = (state_q == RD_WAIT) && (cnt_q == '0);
    can_issue   = (state_q == IDLE) || (state_q == BLOCKED) || rd_done;
    lsu_pend    = (lsu_op != MEM_DISABLE);
    ldr_pend    = ldr_req && (state_q == IDLE);
    lsu_is_read = (lsu_op == MEM_READ_SEXT) || (lsu_op == MEM_READ_ZEXT);

    case (state_q)
      RD_WAIT: begin
        if (rd_done) begin
          rsp_valid = 1'b1;
          rsp_data  = rd_ext;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BLOCKED: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        state_d   = IDLE;
      end
      default: ;
    endcase

    if (can_issue) begin
      if (lsu_pend && (!ldr_pend || last_ldr_q)) begin
        lsu_gnt    = 1'b1;
        last_ldr_d = 1'b0;
        if (misaligned) begin
          state_d = BLOCKED;
        end else if (lsu_op == MEM_WRITE) begin
          ram_en   = 1'b1;
          ram_addr = lsu_addr;
          ram_web  = wr_web;
          ram_din  = wr_din;
        end else if (lsu_is_read) begin
          ram_en    = 1'b1;
          ram_addr  = lsu_addr;
          state_d   = RD_WAIT;
          cnt_d     = CNT_W'(READ_LATENCY - 1);
          rd_sext_d = (lsu_op == MEM_READ_SEXT);
          rd_size_d = lsu_size;
          rd_lo_d   = lsu_addr[1:0];
        end
      end else if (ldr_pend) begin
        ldr_gnt    = 1'b1;
        last_ldr_d = 1'b1;
        ram_en     = 1'b1;
        ram_addr   = ldr_addr;
        ram_web    = 4'b1111;
        ram_din    = ldr_wdata;
      end
    end

    // Outputs are forced low while reset is held, independent of the clock.
    if (!reset) begin
      lsu_gnt   = 1'b0;
      ldr_gnt   = 1'b0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_data  = '0;
      ram_en    = 1'b0;
      ram_web   = 4'b0000;
      ram_addr  = '0;
      ram_din   = '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random traffic,
// all compared each cycle against a transaction-level model of the port.
module tb_mem_port_arbiter;

  localparam int RL = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  lsu_op;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr;
  logic [31:0] lsu_wdata;
  logic        lsu_gnt;
  logic        ldr_req;
  logic [31:0] ldr_addr;
  logic [31:0] ldr_wdata;
  logic        ldr_gnt;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        ram_en;
  logic [3:0]  ram_web;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;

  mem_port_arbiter #(.READ_LATENCY(RL)) dut (
    .clk       (clk),
    .reset     (reset),
    .lsu_op    (lsu_op),
    .lsu_size  (lsu_size),
    .lsu_addr  (lsu_addr),
    .lsu_wdata (lsu_wdata),
    .lsu_gnt   (lsu_gnt),
    .ldr_req   (ldr_req),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ldr_gnt   (ldr_gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .ram_en    (ram_en),
    .ram_web   (ram_web),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Transaction-level model: at most one outstanding response, due at a cycle number.
  bit pend;
  int due;
  bit perr;
  bit psext;
  int psize;
  int plo;
  bit last_ldr;
  bit e_lg;
  bit e_dg;
  bit hold_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [31:0] ext_model(input logic [31:0] raw, input int size,
                                            input int lo, input bit sext);
    logic [31:0] v;
    v = raw >> (8 * lo);
    if (size == 0) begin
      v = v & 32'hFF;
      if (sext && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 1) begin
      v = v & 32'hFFFF;
      if (sext && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic bit lsu_bad();
    return (lsu_size == 2'd3) || (lsu_size == 2'd1 && lsu_addr % 2 != 0) ||
           (lsu_size == 2'd2 && lsu_addr % 4 != 0);
  endfunction

  task automatic model_reset();
    pend     = 1'b0;
    last_ldr = 1'b1;
  endtask

  task automatic settle_and_check();
    bit          rsp_now, can, lp, dp;
    logic [31:0] e_en, e_web, e_addr, e_din, lo;
    if (!hold_dout) ram_dout = $urandom;
    #2;
    rsp_now = pend && (due == cyc);
    can     = !(pend && due > cyc);
    lp      = (lsu_op != 2'b00);
    dp      = ldr_req && !rsp_now;
    e_lg    = 1'b0;
    e_dg    = 1'b0;
    if (can) begin
      if (lp && dp) begin
        if (last_ldr) e_lg = 1'b1;
        else e_dg = 1'b1;
      end else if (lp) e_lg = 1'b1;
      else if (dp) e_dg = 1'b1;
    end
    check("lsu_gnt", 32'(lsu_gnt), 32'(e_lg));
    check("ldr_gnt", 32'(ldr_gnt), 32'(e_dg));
    check("rsp_valid", 32'(rsp_valid), 32'(rsp_now));
    check("rsp_err", 32'(rsp_err), 32'(rsp_now && perr));
    if (rsp_now && !perr) check("rsp_data", rsp_data, ext_model(ram_dout, psize, plo, psext));
    else check("rsp_data", rsp_data, 32'h0);

    lo = lsu_addr % 4;
    if (e_lg && lsu_bad()) begin
      check("ram_en", 32'(ram_en), 32'h0);
      check("ram_web", 32'(ram_web), 32'h0);
    end else if (e_lg && lsu_op == 2'b11) begin
      e_web = (lsu_size == 2'd0) ? (32'h1 << lo) : (lsu_size == 2'd1) ? (32'h3 << lo) : 32'hF;
      e_din = (lsu_size == 2'd0) ? (lsu_wdata & 32'hFF) * 32'h0101_0101 :
              (lsu_size == 2'd1) ? (lsu_wdata & 32'hFFFF) * 32'h0001_0001 : lsu_wdata;
      check("ram_en", 32'(ram_en), 32'h1);
      check("ram_web", 32'(ram_web), e_web);
      check("ram_addr", ram_addr, lsu_addr);
      check("ram_din", ram_din, e_din);
    end else if (e_lg) begin
      check("ram_en", 32'(ram_en), 32'h1);
      check("ram_web", 32'(ram_web), 32'h0);
      check("ram_addr", ram_addr, lsu_addr);
    end else begin
      e_en   = e_dg ? 32'h1 : 32'h0;
      e_web  = e_dg ? 32'hF : 32'h0;
      e_addr = e_dg ? ldr_addr : 32'h0;
      e_din  = e_dg ? ldr_wdata : 32'h0;
      check("ram_en", 32'(ram_en), e_en);
      check("ram_web", 32'(ram_web), e_web);
      check("ram_addr", ram_addr, e_addr);
      check("ram_din", ram_din, e_din);
    end
  endtask

  task automatic advance();
    if (pend && due == cyc) pend = 1'b0;
    if (e_lg) begin
      last_ldr = 1'b0;
      $display("cyc %0d: lsu grant op=%0d size=%0d addr=0x%08h", cyc, lsu_op, lsu_size, lsu_addr);
      if (lsu_bad()) begin
        pend = 1'b1; due = cyc + 1; perr = 1'b1;
      end else if (lsu_op != 2'b11) begin
        pend = 1'b1; due = cyc + RL; perr = 1'b0;
        psext = (lsu_op == 2'b01); psize = int'(lsu_size); plo = int'(lsu_addr % 4);
      end
    end
    if (e_dg) begin
      last_ldr = 1'b1;
      $display("cyc %0d: ldr grant addr=0x%08h data=0x%08h", cyc, ldr_addr, ldr_wdata);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic cycle();
    settle_and_check();
    advance();
  endtask

  initial begin
    reset = 1'b0;
    lsu_op = 2'b11; lsu_size = 2'b10; lsu_addr = 32'h10; lsu_wdata = 32'h1;
    ldr_req = 1'b1; ldr_addr = 32'h20; ldr_wdata = 32'h2;
    ram_dout = 32'h0; hold_dout = 1'b0;
    #1;
    check("rst_lsu_gnt", 32'(lsu_gnt), 32'h0);
    check("rst_ldr_gnt", 32'(ldr_gnt), 32'h0);
    check("rst_ram_en", 32'(ram_en), 32'h0);
    check("rst_ram_web", 32'(ram_web), 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_data", rsp_data, 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    lsu_op = 2'b00; ldr_req = 1'b0;
    reset = 1'b1;

    // Both requesters continuously pending: LSU first, then strict alternation.
    for (int i = 0; i < 4; i++) begin
      lsu_op = 2'b11; lsu_size = 2'b10; lsu_addr = 32'h40 + 32'(4 * i); lsu_wdata = $urandom;
      ldr_req = 1'b1; ldr_addr = 32'h80 + 32'(4 * i); ldr_wdata = $urandom;
      settle_and_check();
      check("rr_lsu_gnt", 32'(lsu_gnt), (i % 2 == 0) ? 32'h1 : 32'h0);
      check("rr_ldr_gnt", 32'(ldr_gnt), (i % 2 == 1) ? 32'h1 : 32'h0);
      advance();
    end
    lsu_op = 2'b00; ldr_req = 1'b0;

    // Byte store to 0x103.
    lsu_op = 2'b11; lsu_size = 2'b00; lsu_addr = 32'h103; lsu_wdata = 32'hAB;
    settle_and_check();
    check("sb_gnt", 32'(lsu_gnt), 32'h1);
    check("sb_web", 32'(ram_web), 32'h8);
    check("sb_din", ram_din, 32'hABAB_ABAB);
    advance();
    lsu_op = 2'b00;

    // Sign-extended half load from 0x102.
    hold_dout = 1'b1; ram_dout = 32'h8001_0000;
    lsu_op = 2'b01; lsu_size = 2'b01; lsu_addr = 32'h102;
    settle_and_check();
    check("lh_gnt", 32'(lsu_gnt), 32'h1);
    advance();
    lsu_op = 2'b00;
    settle_and_check();
    check("lh_early", 32'(rsp_valid), 32'h0);
    advance();
    settle_and_check();
    check("lh_valid", 32'(rsp_valid), 32'h1);
    check("lh_data", rsp_data, 32'hFFFF_8001);
    advance();
    hold_dout = 1'b0;

    // Misaligned word load.
    lsu_op = 2'b10; lsu_size = 2'b10; lsu_addr = 32'h102;
    settle_and_check();
    check("mis_gnt", 32'(lsu_gnt), 32'h1);
    check("mis_ram_en", 32'(ram_en), 32'h0);
    advance();
    lsu_op = 2'b00;
    settle_and_check();
    check("mis_valid", 32'(rsp_valid), 32'h1);
    check("mis_err", 32'(rsp_err), 32'h1);
    check("mis_data", rsp_data, 32'h0);
    advance();

    // Reset one cycle after a read grant.
    lsu_op = 2'b10; lsu_size = 2'b10; lsu_addr = 32'h100;
    cycle();
    lsu_op = 2'b00; ldr_req = 1'b1; ldr_addr = 32'h44; ldr_wdata = 32'h5;
    settle_and_check();
    reset = 1'b0;
    #1;
    check("arst_ram_en", 32'(ram_en), 32'h0);
    check("arst_ldr_gnt", 32'(ldr_gnt), 32'h0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    ldr_req = 1'b0;
    reset = 1'b1;
    cyc++;
    for (int i = 0; i < 4; i++) begin
      settle_and_check();
      check("no_rsp_after_rst", 32'(rsp_valid), 32'h0);
      advance();
    end

    // Random traffic; requesters hold their fields until granted.
    for (int i = 0; i < 400; i++) begin
      if (lsu_op == 2'b00 && $urandom_range(0, 2) != 0) begin
        lsu_op    = 2'($urandom_range(1, 3));
        lsu_size  = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        lsu_addr  = $urandom & 32'hFFF;
        lsu_wdata = $urandom;
      end
      if (!ldr_req && $urandom_range(0, 2) == 0) begin
        ldr_req   = 1'b1;
        ldr_addr  = $urandom & 32'hFFC;
        ldr_wdata = $urandom;
      end
      settle_and_check();
      advance();
      if (e_lg) lsu_op = 2'b00;
      if (e_dg) ldr_req = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
